// File: rtl/datapath_sequencer.sv
// Expands 3-bit macro-instructions into per-cycle control words (l1, l2, s1, s2, f)
// for the two-register add/sub datapath. Supports load, add/sub, swap, clear and multiply-by-x.
module datapath_sequencer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       op,
  input  logic [CNT_W-1:0] x,
  input  logic             start,
  output logic             l1,
  output logic             l2,
  output logic [1:0]       s1,
  output logic [1:0]       s2,
  output logic             f,
  output logic             busy,
  output logic             done
);

  typedef enum logic {ST_IDLE = 1'b0, ST_EXEC = 1'b1} state_t;

  localparam logic [2:0] OP_LD1  = 3'b000;
  localparam logic [2:0] OP_LD2  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_SWAP = 3'b100;
  localparam logic [2:0] OP_CLR  = 3'b101;
  localparam logic [2:0] OP_MULX = 3'b110;

  localparam logic [1:0] SEL_X  = 2'b00;
  localparam logic [1:0] SEL_R1 = 2'b01;
  localparam logic [1:0] SEL_R2 = 2'b10;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_step, w_step_nxt;
  logic [CNT_W-1:0] r_count, w_count_nxt;
  logic [2:0]       r_op, w_op_nxt;
  logic             r_done, w_done_nxt;
  logic             w_last;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_step  <= 2'd0;
      r_count <= CNT_ZERO;
      r_op    <= 3'b000;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_step  <= w_step_nxt;
      r_count <= w_count_nxt;
      r_op    <= w_op_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Final micro-op of the latched instruction; MULX ends on the clear when n=0, else on the last add
  always_comb begin
    w_last = 1'b0;
    case (r_op)
      OP_LD1, OP_LD2: w_last = (r_step == 2'd1);
      OP_SWAP:        w_last = (r_step == 2'd2);
      OP_MULX:        w_last = (r_step == 2'd0) ? (r_count == CNT_ZERO) : (r_count == CNT_ONE);
      default:        w_last = (r_step == 2'd0);
    endcase
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    w_count_nxt = r_count;
    w_op_nxt    = r_op;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_EXEC;
          w_op_nxt    = op;
          w_count_nxt = x;
          w_step_nxt  = 2'd0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (w_last) begin
          w_state_nxt = ST_IDLE;
          w_step_nxt  = 2'd0;
          w_done_nxt  = 1'b1;
        end else if ((r_op == OP_MULX) && (r_step != 2'd0)) begin
          w_count_nxt = r_count - CNT_ONE;
        end else begin
          w_step_nxt = r_step + 2'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Control-word decode from registered state only
  always_comb begin
    l1 = 1'b0;
    l2 = 1'b0;
    s1 = SEL_X;
    s2 = SEL_X;
    f  = 1'b0;
    if (r_state == ST_EXEC) begin
      case (r_op)
        OP_LD1: begin
          l1 = 1'b1;
          s2 = (r_step == 2'd0) ? SEL_X : SEL_R1;
          f  = (r_step == 2'd0);
        end
        OP_LD2: begin
          l2 = 1'b1;
          s2 = (r_step == 2'd0) ? SEL_X : SEL_R2;
          f  = (r_step == 2'd0);
        end
        OP_ADD, OP_SUB: begin
          l1 = 1'b1;
          s1 = SEL_R1;
          s2 = SEL_R2;
          f  = (r_op == OP_SUB);
        end
        OP_SWAP: begin
          l1 = (r_step != 2'd1);
          l2 = (r_step == 2'd1);
          s1 = SEL_R1;
          s2 = SEL_R2;
          f  = (r_step != 2'd0);
        end
        OP_CLR: begin
          l1 = 1'b1;
          l2 = 1'b1;
          s1 = SEL_R1;
          s2 = SEL_R1;
          f  = 1'b1;
        end
        OP_MULX: begin
          l1 = 1'b1;
          s1 = SEL_R1;
          s2 = (r_step == 2'd0) ? SEL_R1 : SEL_R2;
          f  = (r_step == 2'd0);
        end
        default: begin
          l1 = 1'b0;
        end
      endcase
    end else begin
      l1 = 1'b0;
    end
  end

  assign busy = (r_state == ST_EXEC);
  assign done = r_done;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench for datapath_sequencer: drives macro-ops, models the downstream
// R1/R2 datapath from the emitted control words and compares against hand-computed values.
module tb_datapath_sequencer;
  logic       clk;
  logic       rst;
  logic [2:0] op;
  logic [3:0] x;
  logic       start;
  logic       l1, l2, f, busy, done;
  logic [1:0] s1, s2;

  logic [3:0] r1, r2, bus1, bus2, alu;
  int checks;
  int errors;

  datapath_sequencer #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst), .op(op), .x(x), .start(start),
    .l1(l1), .l2(l2), .s1(s1), .s2(s2), .f(f), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream datapath model (not reset: registers keep their value across rst)
  always_comb begin
    case (s1)
      2'b00:   bus1 = x;
      2'b01:   bus1 = r1;
      2'b10:   bus1 = r2;
      default: bus1 = 4'hx;
    endcase
    case (s2)
      2'b00:   bus2 = x;
      2'b01:   bus2 = r1;
      2'b10:   bus2 = r2;
      default: bus2 = 4'hx;
    endcase
    alu = f ? (bus1 - bus2) : (bus1 + bus2);
  end

  always @(posedge clk) begin
    if (l1) r1 <= alu;
    if (l2) r2 <= alu;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge after the done cycle
  task automatic run_op(input string tag, input logic [2:0] o, input logic [3:0] xv,
                        input logic [3:0] xafter, input int exp_cycles);
    int n;
    op = o; x = xv; start = 1'b1;
    @(negedge clk);
    start = 1'b0; x = xafter;
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    check({tag, " cycles"}, n, exp_cycles);
    check({tag, " done"}, done, 1);
    @(negedge clk);
    check({tag, " done_one_shot"}, done, 0);
  endtask

  initial begin
    int dones, busys;
    checks = 0; errors = 0;
    r1 = 4'd0; r2 = 4'd0;
    op = 3'b000; x = 4'd0; start = 1'b0;
    rst = 1'b1;
    #1;
    check("reset_outputs", {l1, l2, s1, s2, f, busy, done}, 9'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op("ld1", 3'b000, 4'd5, 4'd5, 2);
    run_op("ld2", 3'b001, 4'd3, 4'd3, 2);
    check("ld r1", r1, 5);
    check("ld r2", r2, 3);

    run_op("add", 3'b010, 4'd0, 4'd0, 1);
    check("add r1", r1, 8);
    run_op("sub", 3'b011, 4'd0, 4'd0, 1);
    check("sub r1", r1, 5);

    // SWAP with per-step control word checks {l1,l2,s1,s2,f}
    op = 3'b100; start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("swap w0", {l1, l2, s1, s2, f}, 7'b1_0_01_10_0);
    @(negedge clk);
    check("swap w1", {l1, l2, s1, s2, f}, 7'b0_1_01_10_1);
    @(negedge clk);
    check("swap w2", {l1, l2, s1, s2, f}, 7'b1_0_01_10_1);
    @(negedge clk);
    check("swap done", done, 1);
    check("swap r1", r1, 3);
    check("swap r2", r2, 5);
    @(negedge clk);

    run_op("mulx3", 3'b110, 4'd3, 4'd9, 4);
    check("mulx3 r1", r1, 15);
    run_op("mulx6", 3'b110, 4'd6, 4'd6, 7);
    check("mulx6 r1", r1, 14);
    run_op("mulx0", 3'b110, 4'd0, 4'd0, 1);
    check("mulx0 r1", r1, 0);

    run_op("clr", 3'b101, 4'd0, 4'd0, 1);
    check("clr r1r2", {r1, r2}, 8'h00);
    run_op("nop", 3'b111, 4'd9, 4'd9, 1);
    check("nop r1r2", {r1, r2}, 8'h00);

    run_op("ld1b", 3'b000, 4'd1, 4'd1, 2);
    run_op("ld2b", 3'b001, 4'd2, 4'd2, 2);

    // start held high across three SWAPs: accepted only in IDLE/done cycles
    op = 3'b100; start = 1'b1;
    dones = 0; busys = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) dones++;
      if (busy) busys++;
    end
    start = 1'b0;
    check("held dones", dones, 3);
    check("held busys", busys, 9);
    @(negedge clk);
    check("held idle", {busy, done}, 2'b00);
    check("held r1r2", {r1, r2}, 8'h21);

    // Reset during cycle 2 of MULX x=7
    op = 3'b110; x = 4'd7; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    check("mulx7 busy", busy, 1);
    rst = 1'b1;
    #1;
    check("abort outputs", {l1, l2, s1, s2, f, busy, done}, 9'd0);
    @(negedge clk);
    check("abort no_done", {busy, done}, 2'b00);
    rst = 1'b0;
    @(negedge clk);
    check("abort no_done2", {busy, done}, 2'b00);
    check("abort r1", r1, 0);
    run_op("post_rst add", 3'b010, 4'd0, 4'd0, 1);
    check("post_rst r1", r1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
